// File: rtl/tl_pkg.sv
// =============================================================================
// Module      : tl_pkg
// Description : Shared types for the TileLink crossbar channel arbiters.
// Revision    : 1.0
// =============================================================================
`default_nettype none

package tl_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_HOLD  = 2'd1,
        ARB_BURST = 2'd2
    } arb_state_e;

endpackage : tl_pkg

`default_nettype wire

// File: rtl/tl_rr_prio_sel.sv
// =============================================================================
// Module      : tl_rr_prio_sel
// Description : Combinational round-robin priority selector (first request at
//               or above the pointer, wrapping to the lowest index).
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tl_rr_prio_sel #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic             hi_found;
    logic             lo_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Descending scan: the last hit written is the lowest index, so hi_idx is
    // the first request at/above the pointer and lo_idx the wrap-around choice.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
                if (IDX_W'(i) >= ptr_i) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        valid_o = lo_found;
        if (hi_found) begin
            idx_o = hi_idx;
        end else if (lo_found) begin
            idx_o = lo_idx;
        end else begin
            idx_o = ptr_i;
        end
        gnt_o = '0;
        for (int i = 0; i < N; i++) begin
            gnt_o[i] = lo_found && (idx_o == IDX_W'(i));
        end
    end

endmodule : tl_rr_prio_sel

`default_nettype wire

// File: rtl/tl_xbar_rr_arbiter.sv
// =============================================================================
// Module      : tl_xbar_rr_arbiter
// Description : Per-slave-port round-robin arbiter with message-level grant lock.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tl_xbar_rr_arbiter
    import tl_pkg::*;
#(
    parameter int  MASTER_NUM = 4,
    parameter type DATA_T     = logic [0:0],
    parameter int  IDX_W      = $clog2(MASTER_NUM)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [MASTER_NUM-1:0]    inp_valid_i,
    output logic [MASTER_NUM-1:0]    inp_ready_o,
    input  logic [MASTER_NUM-1:0]    inp_last_i,
    input  DATA_T [MASTER_NUM-1:0]   inp_data_i,
    output logic                     oup_valid_o,
    input  logic                     oup_ready_i,
    output DATA_T                    oup_data_o,
    output logic [IDX_W-1:0]         oup_idx_o
);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic [MASTER_NUM-1:0] cand_gnt;
    logic [IDX_W-1:0]      cand_idx;
    logic                  cand_any;
    logic [IDX_W-1:0]      grant_idx;
    logic [MASTER_NUM-1:0] lock_onehot;
    logic                  handshake;
    logic                  grant_last;

    tl_rr_prio_sel #(
        .N     (MASTER_NUM),
        .IDX_W (IDX_W)
    ) u_prio_sel (
        .req_i   (inp_valid_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (cand_gnt),
        .idx_o   (cand_idx),
        .valid_o (cand_any)
    );

    assign lock_onehot = MASTER_NUM'(1) << lock_idx_q;

    // While reset is asserted the outputs are forced to their reset values even
    // if upstream still presents a request.
    always_comb begin
        if (rst_i) begin
            grant_idx = '0;
        end else if (state_q == ARB_IDLE) begin
            grant_idx = cand_idx;
        end else begin
            grant_idx = lock_idx_q;
        end

        oup_idx_o   = grant_idx;
        oup_data_o  = inp_data_i[grant_idx];
        oup_valid_o = inp_valid_i[grant_idx] && !rst_i;

        if (rst_i) begin
            inp_ready_o = '0;
        end else if (state_q == ARB_IDLE) begin
            inp_ready_o = cand_gnt & {MASTER_NUM{oup_ready_i}};
        end else begin
            inp_ready_o = lock_onehot & {MASTER_NUM{oup_ready_i}};
        end
    end

    assign handshake  = oup_valid_o && oup_ready_i;
    assign grant_last = inp_last_i[grant_idx];

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (cand_any) begin
                    lock_idx_d = cand_idx;
                    if (!handshake) begin
                        state_d = ARB_HOLD;
                    end else if (!grant_last) begin
                        state_d = ARB_BURST;
                    end
                end
            end
            ARB_HOLD, ARB_BURST: begin
                if (handshake) begin
                    state_d = grant_last ? ARB_IDLE : ARB_BURST;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (handshake && grant_last) begin
            rr_ptr_d = (grant_idx == IDX_W'(MASTER_NUM - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

endmodule : tl_xbar_rr_arbiter

`default_nettype wire

// File: tb/tb_tl_xbar_rr_arbiter.sv
// =============================================================================
// Module      : tb_tl_xbar_rr_arbiter
// Description : Directed self-checking bench for tl_xbar_rr_arbiter.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tb_tl_xbar_rr_arbiter;

    localparam int N = 4;
    typedef logic [7:0] data_t;

    logic          clk;
    logic          rst;
    logic [N-1:0]  inp_valid;
    logic [N-1:0]  inp_ready;
    logic [N-1:0]  inp_last;
    data_t [N-1:0] inp_data;
    logic          oup_valid;
    logic          oup_ready;
    data_t         oup_data;
    logic [1:0]    oup_idx;

    int checks = 0;
    int errors = 0;

    tl_xbar_rr_arbiter #(
        .MASTER_NUM (N),
        .DATA_T     (data_t)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .inp_valid_i (inp_valid),
        .inp_ready_o (inp_ready),
        .inp_last_i  (inp_last),
        .inp_data_i  (inp_data),
        .oup_valid_o (oup_valid),
        .oup_ready_i (oup_ready),
        .oup_data_o  (oup_data),
        .oup_idx_o   (oup_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] rdy,
                           input logic [1:0] idx, input data_t d);
        chk({tag, ".valid"}, 32'(oup_valid), 32'(v));
        chk({tag, ".ready"}, 32'(inp_ready), 32'(rdy));
        chk({tag, ".idx"},   32'(oup_idx),   32'(idx));
        chk({tag, ".data"},  32'(oup_data),  32'(d));
    endtask

    // Advance past the next rising edge so state updates are visible.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
        inp_valid = v;
        inp_last  = l;
        oup_ready = r;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        inp_valid = '0;
        inp_last  = '0;
        oup_ready = 1'b0;
        for (int i = 0; i < N; i++) inp_data[i] = 8'hA0 + 8'(i);

        #2;
        chk_out("reset", 1'b0, 4'b0000, 2'd0, 8'hA0);
        @(posedge clk);
        #1 rst = 1'b0;

        // No requests: nothing offered regardless of slave ready.
        drive(4'b0000, 4'b0000, 1'b1);
        chk_out("idle_rdy1", 1'b0, 4'b0000, 2'd0, 8'hA0);
        cyc();

        // Single-beat round robin, back-to-back with no bubble.
        drive(4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk_out($sformatf("rr%0d", i), 1'b1, 4'(1 << (i % 4)), 2'(i % 4), 8'hA0 + 8'(i % 4));
            cyc();
        end

        // Move pointer to 2 with a single beat from master 1.
        drive(4'b0010, 4'b0010, 1'b1);
        chk_out("pre_burst", 1'b1, 4'b0010, 2'd1, 8'hA1);
        cyc();

        // Master 2 four-beat burst while master 1 waits.
        for (int b = 0; b < 4; b++) begin
            drive(4'b0110, (b == 3) ? 4'b0110 : 4'b0010, 1'b1);
            chk_out($sformatf("burst%0d", b), 1'b1, 4'b0100, 2'd2, 8'hA2);
            cyc();
        end
        drive(4'b0110, 4'b0010, 1'b1);
        chk_out("after_burst", 1'b1, 4'b0010, 2'd1, 8'hA1);
        cyc();

        // Pointer 2 -> 3 via a single beat from master 2.
        drive(4'b0100, 4'b0100, 1'b1);
        chk_out("pre_stall", 1'b1, 4'b0100, 2'd2, 8'hA2);
        cyc();

        // Stall: masters 0 and 3 valid, slave not ready.
        for (int s = 0; s < 5; s++) begin
            drive(4'b1001, 4'b1001, 1'b0);
            chk_out($sformatf("stall%0d", s), 1'b1, 4'b0000, 2'd3, 8'hA3);
            cyc();
        end
        // Locked master withdraws valid: grant must stay frozen on master 3.
        drive(4'b0001, 4'b1001, 1'b0);
        chk_out("withdraw", 1'b0, 4'b0000, 2'd3, 8'hA3);
        cyc();
        drive(4'b1001, 4'b1001, 1'b1);
        chk_out("stall_release", 1'b1, 4'b1000, 2'd3, 8'hA3);
        cyc();
        chk_out("stall_next", 1'b1, 4'b0001, 2'd0, 8'hA0);
        cyc();

        // Pointer now 1; only master 3 sends, pointer wraps to 0.
        drive(4'b1000, 4'b1000, 1'b1);
        chk_out("wrap_m3", 1'b1, 4'b1000, 2'd3, 8'hA3);
        cyc();
        drive(4'b0011, 4'b0011, 1'b1);
        chk_out("wrap_m0", 1'b1, 4'b0001, 2'd0, 8'hA0);
        cyc();
        chk_out("wrap_m1", 1'b1, 4'b0010, 2'd1, 8'hA1);
        cyc();

        // Master 1 starts a four-beat burst; reset lands after beat 2.
        drive(4'b0010, 4'b0000, 1'b1);
        chk_out("rst_b0", 1'b1, 4'b0010, 2'd1, 8'hA1);
        cyc();
        chk_out("rst_b1", 1'b1, 4'b0010, 2'd1, 8'hA1);
        cyc();
        rst = 1'b1;
        #1;
        chk_out("rst_mid", 1'b0, 4'b0000, 2'd0, 8'hA0);
        #1 rst = 1'b0;
        drive(4'b0001, 4'b0001, 1'b1);
        chk_out("post_rst", 1'b1, 4'b0001, 2'd0, 8'hA0);
        cyc();

        // Idle with pointer 1: index shows pointer, nothing ready.
        drive(4'b0000, 4'b0000, 1'b0);
        chk_out("idle_rdy0", 1'b0, 4'b0000, 2'd1, 8'hA1);
        drive(4'b0000, 4'b0000, 1'b1);
        chk_out("idle_rdy1b", 1'b0, 4'b0000, 2'd1, 8'hA1);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tl_xbar_rr_arbiter

`default_nettype wire
